// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer: walks a 2-bit select across the enabled channels of a
// 4:1 byte mux, holding each channel for dwell+1 cycles, with step/wrap
// pulses on every advance and a start_err pulse for an empty mask.
module mux_sel_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [3:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  output logic               enable,
  output logic               busy,
  output logic               step,
  output logic               wrap,
  output logic               start_err
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state;
  logic [DWELL_W-1:0] count;
  logic [1:0]         first_ch;
  logic [1:0]         next_ch;

  // Channel search: lowest set bit for start, next set bit above sel (mod 4)
  // for an advance. A single-bit mask makes next_ch fall back to sel itself.
  always_comb begin
    // NOTE: every variable gets a default before the loops so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    first_ch = 2'd0;
    next_ch  = sel;
    for (int i = 3; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 2'(i);
    end
    // Descending offsets so the nearest enabled channel above sel wins.
    for (int k = 3; k >= 1; k--) begin
      if (ch_mask[sel + 2'(k)]) next_ch = sel + 2'(k);
    end
  end

  // Enable and busy are the state register itself, so they stay registered.
  assign enable = (state == ST_RUN);
  assign busy   = (state == ST_RUN);

  // State, select, dwell counter and single-cycle event pulses.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, regardless of statement order.
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= 2'd0;
      count     <= '0;
      step      <= 1'b0;
      wrap      <= 1'b0;
      start_err <= 1'b0;
    end else begin
      step      <= 1'b0;
      wrap      <= 1'b0;
      start_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            if (ch_mask != 4'b0000) begin
              state <= ST_RUN;
              sel   <= first_ch;
              count <= dwell;
            end else begin
              start_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            // stop beats an advance due on the same edge; sel is kept.
            state <= ST_IDLE;
          end else if (count != '0) begin
            count <= count - 1'b1;
          end else if (ch_mask == 4'b0000) begin
            // Nothing left to advance to: drop out quietly with sel held.
            state <= ST_IDLE;
          end else begin
            sel   <= next_ch;
            count <= dwell;
            step  <= 1'b1;
            wrap  <= (next_ch <= sel);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Self-checking bench for mux_sel_sequencer: a directed vector table, a few
// hand-written multi-cycle corner sequences, then random stimulus compared
// against a cycle-count reference model.
module tb_mux_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic [7:0] dwell = 8'd0;
  logic [1:0] sel;
  logic       enable, busy, step, wrap, start_err;

  int n_cmp = 0;
  int n_bad = 0;

  mux_sel_sequencer #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .ch_mask(ch_mask), .dwell(dwell), .sel(sel), .enable(enable),
    .busy(busy), .step(step), .wrap(wrap), .start_err(start_err)
  );

  always #5 clk = ~clk;

  // Reference model: channel time is tracked as cycles remaining in the
  // current channel (dwell+1 at entry), channels found by modular search.
  bit m_run = 1'b0;
  int m_sel = 0;
  int m_left = 0;
  bit m_step = 1'b0, m_wrap = 1'b0, m_err = 1'b0;

  function automatic int lowest_ch(input bit [3:0] m);
    for (int c = 0; c < 4; c++) if (m[c]) return c;
    return 0;
  endfunction

  function automatic int next_above(input int cur, input bit [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(cur + k) % 4]) return (cur + k) % 4;
    return cur;
  endfunction

  task automatic model_edge(input bit r, input bit s, input bit p,
                            input bit [3:0] m, input bit [7:0] d);
    int nxt;
    m_step = 1'b0; m_wrap = 1'b0; m_err = 1'b0;
    if (r) begin
      m_run = 1'b0; m_sel = 0; m_left = 0;
    end else if (!m_run) begin
      if (s && !p) begin
        if (m != 4'b0000) begin
          m_run = 1'b1; m_sel = lowest_ch(m); m_left = int'(d) + 1;
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (p) begin
      m_run = 1'b0;
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m == 4'b0000) begin
          m_run = 1'b0;
        end else begin
          nxt    = next_above(m_sel, m);
          m_step = 1'b1;
          m_wrap = (nxt <= m_sel);
          m_sel  = nxt;
          m_left = int'(d) + 1;
        end
      end
    end
  endtask

  // Apply one cycle of inputs, advance the model, sample 1 ns after the edge.
  task automatic tick(input bit r, input bit s, input bit p,
                      input bit [3:0] m, input bit [7:0] d);
    rst = r; start = s; stop = p; ch_mask = m; dwell = d;
    @(posedge clk);
    model_edge(r, s, p, m, d);
    #1;
  endtask

  // Outputs packed as {sel, enable, busy, step, wrap, start_err}.
  function automatic logic [6:0] outs();
    return {sel, enable, busy, step, wrap, start_err};
  endfunction

  function automatic logic [6:0] pack(input bit [1:0] s, input bit en,
                                      input bit st, input bit wr, input bit er);
    return {s, en, en, st, wr, er};
  endfunction

  task automatic check(input string name, input logic [6:0] act,
                       input logic [6:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: {sel,en,busy,step,wrap,err} got %b, want %b", name, act, exp);
    end
  endtask

  typedef struct {
    bit       r, s, p;
    bit [3:0] m;
    bit [7:0] d;
    bit [1:0] e_sel;
    bit       e_en, e_step, e_wrap, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit s, input bit p, input bit [3:0] m,
                     input bit [7:0] d, input bit [1:0] es, input bit een,
                     input bit est, input bit ewr, input bit eer);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.m = m; v.d = d;
    v.e_sel = es; v.e_en = een; v.e_step = est; v.e_wrap = ewr; v.e_err = eer;
    vecs.push_back(v);
  endtask

  initial begin
    // Reset state.
    add(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 0);
    // All four channels, dwell=2: 0,0,0,1,1,1,2,2,2,3,3,3,0.
    add(0, 1, 0, 4'hF, 2, 0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++)
      add(0, 0, 0, 4'hF, 2, 2'(((i + 1) / 3) % 4), 1,
          ((i + 1) % 3) == 0, i == 11, 0);
    add(0, 0, 1, 4'hF, 2, 0, 0, 0, 0, 0);
    // Channels B and D, dwell=0: 1,3,1,3,1 with wrap on each 3->1.
    add(0, 1, 0, 4'hA, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 4'hA, 0, 3, 1, 1, 0, 0);
    add(0, 0, 0, 4'hA, 0, 1, 1, 1, 1, 0);
    add(0, 0, 0, 4'hA, 0, 3, 1, 1, 0, 0);
    add(0, 0, 0, 4'hA, 0, 1, 1, 1, 1, 0);
    add(0, 0, 1, 4'hA, 0, 1, 0, 0, 0, 0);
    // Single channel C, dwell=1: step+wrap every second cycle.
    add(0, 1, 0, 4'h4, 1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 4'h4, 1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 4'h4, 1, 2, 1, 1, 1, 0);
    add(0, 0, 0, 4'h4, 1, 2, 1, 0, 0, 0);
    add(0, 0, 0, 4'h4, 1, 2, 1, 1, 1, 0);
    add(0, 0, 1, 4'h4, 1, 2, 0, 0, 0, 0);
    // Empty mask start: start_err for exactly one cycle, sel held.
    add(0, 1, 0, 4'h0, 0, 2, 0, 0, 0, 1);
    add(0, 0, 0, 4'h0, 0, 2, 0, 0, 0, 0);
    // start together with stop in IDLE: stop wins.
    add(0, 1, 1, 4'hF, 0, 2, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].m, vecs[i].d);
      check($sformatf("vec%0d", i), outs(),
            pack(vecs[i].e_sel, vecs[i].e_en, vecs[i].e_step,
                 vecs[i].e_wrap, vecs[i].e_err));
    end

    // Mask cleared mid-dwell on channel C: dwell completes, then IDLE at the
    // advance with sel=2 and no step.
    tick(1, 0, 0, 4'h0, 0);
    tick(0, 1, 0, 4'h4, 3);
    check("mask0_enter", outs(), pack(2, 1, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 4'h0, 9);
      check($sformatf("mask0_dwell%0d", i), outs(), pack(2, 1, 0, 0, 0));
    end
    tick(0, 0, 0, 4'h0, 9);
    check("mask0_idle", outs(), pack(2, 0, 0, 0, 0));

    // stop on the same edge as a due advance: IDLE, sel unchanged, no step.
    tick(0, 1, 0, 4'hF, 1);
    tick(0, 0, 0, 4'hF, 1);
    check("stopadv_pre", outs(), pack(0, 1, 0, 0, 0));
    tick(0, 0, 1, 4'hF, 1);
    check("stopadv", outs(), pack(0, 0, 0, 0, 0));

    // Reset mid-dwell on channel D, with start asserted: reset wins, and the
    // block stays idle until a fresh start.
    tick(0, 1, 0, 4'h8, 5);
    tick(0, 0, 0, 4'h8, 5);
    check("rstmid_pre", outs(), pack(3, 1, 0, 0, 0));
    tick(1, 1, 0, 4'h8, 5);
    check("rstmid", outs(), pack(0, 0, 0, 0, 0));
    tick(0, 0, 0, 4'h8, 5);
    check("rstmid_stay", outs(), pack(0, 0, 0, 0, 0));

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      automatic bit       r = ($urandom_range(0, 99) == 0);
      automatic bit       s = ($urandom_range(0, 7) == 0);
      automatic bit       p = ($urandom_range(0, 29) == 0);
      automatic bit [3:0] m = ch_mask;
      automatic bit [7:0] d = dwell;
      if ($urandom_range(0, 5) == 0) m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) d = 8'($urandom_range(0, 4));
      tick(r, s, p, m, d);
      check($sformatf("rand%0d", i), outs(),
            pack(2'(m_sel), m_run, m_step, m_wrap, m_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
